// File: rtl/dircc_timer_pkg.sv
// Shared constants for the interval-timer host: register map, control bits,
// command encodings and host FSM states.
package dircc_timer_pkg;

  // Timer register addresses
  localparam logic [2:0] ADDR_STATUS = 3'd0;
  localparam logic [2:0] ADDR_CTRL   = 3'd1;
  localparam logic [2:0] ADDR_PERL   = 3'd2;
  localparam logic [2:0] ADDR_PERH   = 3'd3;
  localparam logic [2:0] ADDR_SNAPL  = 3'd4;
  localparam logic [2:0] ADDR_SNAPH  = 3'd5;

  // Control register bit positions
  localparam int CTRL_ITO   = 0;
  localparam int CTRL_CONT  = 1;
  localparam int CTRL_START = 2;
  localparam int CTRL_STOP  = 3;

  // Local command encodings
  localparam logic [1:0] OP_NOP   = 2'd0;
  localparam logic [1:0] OP_START = 2'd1;
  localparam logic [1:0] OP_STOP  = 2'd2;
  localparam logic [1:0] OP_SNAP  = 2'd3;

  typedef enum logic [3:0] {
    IDLE, WR_PL, WR_PH, WR_CTRL, WR_STOP, WR_SNAP,
    RD_L, RD_H, RD_CAP, CLR_ST, CLR_WAIT, RSP
  } state_t;

endpackage

// File: rtl/dircc_timer_host.sv
// Avalon-MM master for the 16-bit interval timer. Converts START/STOP/SNAP
// commands into register sequences and services the timer interrupt.
// Build option: DIRCC_TIMER_HOST_TIMEOUT_CNT_EN builds the 32-bit
// serviced-interrupt counter; without it timeout_count reads 0.
module dircc_timer_host
  import dircc_timer_pkg::*;
#(
  parameter bit IRQ_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [31:0] cmd_period,
  input  logic        cmd_continuous,
  output logic        rsp_valid,
  output logic [31:0] rsp_snapshot,
  output logic        timeout_pulse,
  output logic [31:0] timeout_count,
  output logic [2:0]  tmr_address,
  output logic        tmr_chipselect,
  output logic        tmr_write_n,
  output logic [15:0] tmr_writedata,
  input  logic [15:0] tmr_readdata,
  input  logic        tmr_irq
);

  state_t      r_state, w_next;
  logic [15:0] r_period_h;
  logic        r_cont;
  logic [15:0] r_snap_lo;
  logic [31:0] r_snapshot;
  logic        r_rsp_valid, r_pulse;
  logic        r_cs, r_wn;
  logic [2:0]  r_addr;
  logic [15:0] r_wd;

  logic        w_cs, w_wn;
  logic [2:0]  w_addr;
  logic [15:0] w_wd;
  logic        w_accept;

  // Interrupt wins over a pending command, so ready drops while irq is high
  assign cmd_ready = (r_state == IDLE) && !tmr_irq;
  assign w_accept  = cmd_valid && cmd_ready;

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (tmr_irq) w_next = CLR_ST;
        else if (w_accept) begin
          case (cmd_op)
            OP_START: w_next = WR_PL;
            OP_STOP:  w_next = WR_STOP;
            OP_SNAP:  w_next = WR_SNAP;
            default:  w_next = RSP;
          endcase
        end
      end
      WR_PL:    w_next = WR_PH;
      WR_PH:    w_next = WR_CTRL;
      WR_CTRL:  w_next = RSP;
      WR_STOP:  w_next = RSP;
      WR_SNAP:  w_next = RD_L;
      RD_L:     w_next = RD_H;
      RD_H:     w_next = RD_CAP;
      RD_CAP:   w_next = RSP;
      CLR_ST:   w_next = CLR_WAIT;
      CLR_WAIT: w_next = IDLE;
      RSP:      w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  // Bus value for the upcoming state; registered so the bus is glitch-free.
  // WR_PL is only entered on accept, so the low period half comes straight
  // from the command port.
  always_comb begin
    w_cs   = 1'b0;
    w_wn   = 1'b1;
    w_addr = ADDR_STATUS;
    w_wd   = '0;
    case (w_next)
      WR_PL:   begin w_cs = 1'b1; w_wn = 1'b0; w_addr = ADDR_PERL; w_wd = cmd_period[15:0]; end
      WR_PH:   begin w_cs = 1'b1; w_wn = 1'b0; w_addr = ADDR_PERH; w_wd = r_period_h; end
      WR_CTRL: begin
        w_cs = 1'b1; w_wn = 1'b0; w_addr = ADDR_CTRL;
        w_wd[CTRL_START] = 1'b1;
        w_wd[CTRL_CONT]  = r_cont;
        w_wd[CTRL_ITO]   = IRQ_EN;
      end
      WR_STOP: begin
        w_cs = 1'b1; w_wn = 1'b0; w_addr = ADDR_CTRL;
        w_wd[CTRL_STOP] = 1'b1;
        w_wd[CTRL_ITO]  = IRQ_EN;
      end
      WR_SNAP: begin w_cs = 1'b1; w_wn = 1'b0; w_addr = ADDR_SNAPL; end
      RD_L:    begin w_cs = 1'b1; w_addr = ADDR_SNAPL; end
      RD_H:    begin w_cs = 1'b1; w_addr = ADDR_SNAPH; end
      CLR_ST:  begin w_cs = 1'b1; w_wn = 1'b0; w_addr = ADDR_STATUS; end
      default: ;
    endcase
  end

  // State, bus, response and snapshot registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cs        <= 1'b0;
      r_wn        <= 1'b1;
      r_addr      <= '0;
      r_wd        <= '0;
      r_rsp_valid <= 1'b0;
      r_pulse     <= 1'b0;
      r_period_h  <= '0;
      r_cont      <= 1'b0;
      r_snap_lo   <= '0;
      r_snapshot  <= '0;
    end else begin
      r_state     <= w_next;
      r_cs        <= w_cs;
      r_wn        <= w_wn;
      r_addr      <= w_addr;
      r_wd        <= w_wd;
      r_rsp_valid <= (w_next == RSP);
      r_pulse     <= (r_state == CLR_ST);
      if (w_accept) begin
        r_period_h <= cmd_period[31:16];
        r_cont     <= cmd_continuous;
      end
      // readdata lags the address by one cycle: RD_H sees snap_l, RD_CAP snap_h
      if (r_state == RD_H)   r_snap_lo  <= tmr_readdata;
      if (r_state == RD_CAP) r_snapshot <= {tmr_readdata, r_snap_lo};
    end
  end

`ifdef DIRCC_TIMER_HOST_TIMEOUT_CNT_EN
  logic [31:0] r_tcnt;
  // Count serviced interrupts; wraps naturally at 32 bits
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  r_tcnt <= '0;
    else if (r_state == CLR_ST) r_tcnt <= r_tcnt + 32'd1;
  end
  assign timeout_count = r_tcnt;
`else
  assign timeout_count = '0;
`endif

  assign tmr_chipselect = r_cs;
  assign tmr_write_n    = r_wn;
  assign tmr_address    = r_addr;
  assign tmr_writedata  = r_wd;
  assign rsp_valid      = r_rsp_valid;
  assign rsp_snapshot   = r_snapshot;
  assign timeout_pulse  = r_pulse;

endmodule

// File: tb/tb_dircc_timer_host.sv
// Directed bench for dircc_timer_host with a minimal timer read/snapshot model.
module tb_dircc_timer_host;

  logic        clk = 0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [31:0] cmd_period;
  logic        cmd_continuous;
  logic        rsp_valid;
  logic [31:0] rsp_snapshot;
  logic        timeout_pulse;
  logic [31:0] timeout_count;
  logic [2:0]  tmr_address;
  logic        tmr_chipselect;
  logic        tmr_write_n;
  logic [15:0] tmr_writedata;
  logic [15:0] tmr_readdata;
  logic        tmr_irq;

  int checks = 0;
  int errors = 0;
  int irq_seen = 0;

  logic [31:0] tmr_counter;
  logic [31:0] tmr_snap;

  always #5 clk = ~clk;

  dircc_timer_host dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_period(cmd_period), .cmd_continuous(cmd_continuous),
    .rsp_valid(rsp_valid), .rsp_snapshot(rsp_snapshot),
    .timeout_pulse(timeout_pulse), .timeout_count(timeout_count),
    .tmr_address(tmr_address), .tmr_chipselect(tmr_chipselect),
    .tmr_write_n(tmr_write_n), .tmr_writedata(tmr_writedata),
    .tmr_readdata(tmr_readdata), .tmr_irq(tmr_irq)
  );

  // Timer model: snap_l write latches the counter, reads return one cycle later
  always @(posedge clk) begin
    if (tmr_chipselect && !tmr_write_n && tmr_address == 3'd4) tmr_snap <= tmr_counter;
    if (tmr_chipselect && tmr_write_n) begin
      if (tmr_address == 3'd4)      tmr_readdata <= tmr_snap[15:0];
      else if (tmr_address == 3'd5) tmr_readdata <= tmr_snap[31:16];
      else                          tmr_readdata <= 16'hDEAD;
    end
  end

  // {cs, write_n, addr, data}
  function automatic logic [20:0] bus();
    return {tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata};
  endfunction

  localparam logic [20:0] BUS_IDLE = {1'b0, 1'b1, 3'd0, 16'h0};

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  // Present a command and step past the accepting edge
  task automatic issue(input logic [1:0] op, input logic [31:0] per, input logic cont);
    cmd_valid = 1; cmd_op = op; cmd_period = per; cmd_continuous = cont;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL accept_ready op=%0d got %b want 1", op, cmd_ready);
    end
    next_cycle();
    cmd_valid = 0;
  endtask

  task automatic test_reset();
    reset = 1; cmd_valid = 0; cmd_op = 0; cmd_period = 0; cmd_continuous = 0; tmr_irq = 0;
    tmr_counter = 0;
    #12;
    reset = 0;
    next_cycle();
    issue(2'd1, 32'h1234_5678, 1'b1);
    next_cycle();          // now mid-START (WR_PH)
    reset = 1;
    @(negedge clk);
    checks++;
    if (bus() !== BUS_IDLE) begin errors++; $display("FAIL reset_bus got %h want %h", bus(), BUS_IDLE); end
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", cmd_ready); end
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp got %b want 0", rsp_valid); end
    checks++;
    if (timeout_count !== 32'h0) begin errors++; $display("FAIL reset_count got %h want 0", timeout_count); end
    checks++;
    if (rsp_snapshot !== 32'h0) begin errors++; $display("FAIL reset_snap got %h want 0", rsp_snapshot); end
    next_cycle();
    reset = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (bus() !== BUS_IDLE || rsp_valid !== 1'b0) begin
        errors++; $display("FAIL post_reset_quiet cyc=%0d bus %h rsp %b want %h 0", i, bus(), rsp_valid, BUS_IDLE);
      end
      next_cycle();
    end
  endtask

  task automatic test_start();
    logic [20:0] exp [0:3];
    exp[0] = {1'b1, 1'b0, 3'd2, 16'h86A0};
    exp[1] = {1'b1, 1'b0, 3'd3, 16'h0001};
    exp[2] = {1'b1, 1'b0, 3'd1, 16'h0007};
    exp[3] = BUS_IDLE;
    issue(2'd1, 32'h0001_86A0, 1'b1);
    for (int k = 1; k <= 4; k++) begin   // cycles t0+1 .. t0+4
      @(negedge clk);
      checks++;
      if (bus() !== exp[k-1]) begin errors++; $display("FAIL start_bus t0+%0d got %h want %h", k, bus(), exp[k-1]); end
      checks++;
      if (rsp_valid !== (k == 4)) begin errors++; $display("FAIL start_rsp t0+%0d got %b want %b", k, rsp_valid, k == 4); end
      checks++;
      if (cmd_ready !== 1'b0) begin errors++; $display("FAIL start_busy t0+%0d got %b want 0", k, cmd_ready); end
      next_cycle();
    end
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL start_done ready %b rsp %b want 1 0", cmd_ready, rsp_valid);
    end
  endtask

  task automatic test_nop();
    issue(2'd0, 32'h0, 1'b0);
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || bus() !== BUS_IDLE) begin
      errors++; $display("FAIL nop_rsp rsp %b bus %h want 1 %h", rsp_valid, bus(), BUS_IDLE);
    end
    next_cycle();
  endtask

  task automatic test_snap();
    logic [20:0] exp [0:4];
    exp[0] = {1'b1, 1'b0, 3'd4, 16'h0};
    exp[1] = {1'b1, 1'b1, 3'd4, 16'h0};
    exp[2] = {1'b1, 1'b1, 3'd5, 16'h0};
    exp[3] = BUS_IDLE;
    exp[4] = BUS_IDLE;
    tmr_counter = 32'h0002_1234;
    issue(2'd3, 32'h0, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      checks++;
      if (bus() !== exp[k-1]) begin errors++; $display("FAIL snap_bus t0+%0d got %h want %h", k, bus(), exp[k-1]); end
      checks++;
      if (rsp_valid !== (k == 5)) begin errors++; $display("FAIL snap_rsp t0+%0d got %b want %b", k, rsp_valid, k == 5); end
      next_cycle();
    end
    tmr_counter = 32'hFFFF_0000;
    // still held after the response
    @(negedge clk);
    checks++;
    if (rsp_snapshot !== 32'h0002_1234) begin errors++; $display("FAIL snap_value got %h want 00021234", rsp_snapshot); end
    next_cycle();
  endtask

  task automatic test_irq(input logic with_stop);
    int exp_cnt;
    irq_seen++;
`ifdef DIRCC_TIMER_HOST_TIMEOUT_CNT_EN
    exp_cnt = irq_seen;
`else
    exp_cnt = 0;
`endif
    tmr_irq = 1;
    if (with_stop) begin cmd_valid = 1; cmd_op = 2'd2; end
    @(negedge clk);                      // cycle t
    checks++;
    if (cmd_ready !== 1'b0) begin errors++; $display("FAIL irq_ready_t got %b want 0", cmd_ready); end
    next_cycle();                        // t+1
    @(negedge clk);
    checks++;
    if (bus() !== {1'b1, 1'b0, 3'd0, 16'h0}) begin errors++; $display("FAIL irq_clr_bus got %h want %h", bus(), {1'b1, 1'b0, 3'd0, 16'h0}); end
    checks++;
    if (cmd_ready !== 1'b0 || timeout_pulse !== 1'b0) begin
      errors++; $display("FAIL irq_t1 ready %b pulse %b want 0 0", cmd_ready, timeout_pulse);
    end
    next_cycle();                        // t+2, timer has dropped irq
    tmr_irq = 0;
    @(negedge clk);
    checks++;
    if (timeout_pulse !== 1'b1 || cmd_ready !== 1'b0 || bus() !== BUS_IDLE) begin
      errors++; $display("FAIL irq_pulse pulse %b ready %b bus %h want 1 0 %h", timeout_pulse, cmd_ready, bus(), BUS_IDLE);
    end
    checks++;
    if (timeout_count !== exp_cnt) begin errors++; $display("FAIL irq_count got %0d want %0d", timeout_count, exp_cnt); end
    next_cycle();                        // t+3
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || timeout_pulse !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL irq_t3 ready %b pulse %b rsp %b want 1 0 0", cmd_ready, timeout_pulse, rsp_valid);
    end
    next_cycle();                        // STOP accepted at t+3 if pending
    cmd_valid = 0;
    if (with_stop) begin
      @(negedge clk);
      checks++;
      if (bus() !== {1'b1, 1'b0, 3'd1, 16'h0009}) begin errors++; $display("FAIL coll_stop_bus got %h want %h", bus(), {1'b1, 1'b0, 3'd1, 16'h0009}); end
      next_cycle();
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1) begin errors++; $display("FAIL coll_stop_rsp got %b want 1", rsp_valid); end
      next_cycle();
    end
    @(negedge clk);
    checks++;
    if (timeout_count !== exp_cnt || timeout_pulse !== 1'b0) begin
      errors++; $display("FAIL irq_after count %0d pulse %b want %0d 0", timeout_count, timeout_pulse, exp_cnt);
    end
    next_cycle();
  endtask

  initial begin
    tmr_readdata = 16'h0;
    tmr_snap = 32'h0;
    test_reset();
    test_start();
    next_cycle();
    test_nop();
    test_snap();
    test_irq(1'b0);
    test_irq(1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
